// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : arb_pkg
// Description : Shared constants, FSM state encoding and helpers for the
//               8-way round-robin arbiter (rr_arbiter8 / rr_pick8).
// Contents    : N_REQ  - number of requesters
//               ID_W   - width of a requester index
//               HOLD_W - width of the optional grant-hold counter
//               state_t (ST_IDLE / ST_GRANT), id_to_onehot()
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int N_REQ  = 8;
    localparam int ID_W   = 3;
    localparam int HOLD_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Binary requester index to one-hot grant vector.
    function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        return N_REQ'(1) << id;
    endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_pick8.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick8
// Description : Combinational rotating-priority picker. Scans req starting at
//               index ptr and wrapping modulo 8; the first set bit wins.
// Ports       : req        in  [7:0] request vector
//               ptr        in  [2:0] index holding highest priority
//               any        out       OR of all request bits
//               win_id     out [2:0] index of the winner (ptr when no request)
//               win_onehot out [7:0] one-hot winner, zero when no request
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             any,
    output logic [ID_W-1:0]  win_id,
    output logic [N_REQ-1:0] win_onehot
);

    logic [2*N_REQ-1:0] w_req_dbl;
    logic [N_REQ-1:0]   w_req_rot;
    logic [ID_W-1:0]    w_offset;

    assign any = |req;

    always_comb begin
        // Doubling the vector turns the rotation into a plain part-select:
        // w_req_rot[i] corresponds to req[(ptr + i) mod 8].
        w_req_dbl = {req, req};
        w_req_rot = w_req_dbl[ptr +: N_REQ];

        // Lowest set bit of the rotated vector is the nearest requester at or
        // after ptr; scan downwards so the lowest index is written last.
        w_offset = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_offset = ID_W'(i);
            end
        end

        // Un-rotate: 3-bit addition wraps modulo 8 naturally.
        win_id     = ptr + w_offset;
        win_onehot = any ? id_to_onehot(win_id) : '0;
    end

endmodule : rr_pick8
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter8
// Description : Round-robin arbiter sharing one resource among 8 requesters.
//               A grant is held until the owner pulses done; on release the
//               priority pointer moves to owner+1 and the next pick happens
//               in the same edge (back-to-back, no idle cycle).
// Parameters  : PTR_RST  - index holding highest priority after reset (0-7)
//               HOLD_MAX - max grant length in cycles (1-65535), used only
//                          when ARB_TIMEOUT_EN is defined
// Macro       : ARB_TIMEOUT_EN - enables the grant-hold counter and forced
//                          release with a one-cycle timeout pulse
// Ports       : clk       in        rising-edge clock
//               rst_n     in        synchronous active-low reset
//               req       in  [7:0] request vector
//               done      in        owner releases resource (GRANT only)
//               gnt       out [7:0] registered one-hot grant, zero when idle
//               gnt_valid out       OR of gnt
//               gnt_id    out [2:0] index of owner, holds last value in idle
//               any_req   out       combinational OR of req
//               timeout   out       one-cycle pulse after a forced release
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int PTR_RST  = 0,
    parameter int HOLD_MAX = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [ID_W-1:0]  gnt_id,
    output logic             any_req,
    output logic             timeout
);

    localparam logic [ID_W-1:0] c_PTR_RST = ID_W'(PTR_RST);

    // Out-of-range HOLD_MAX builds nothing extra; the named scope makes the
    // bad configuration visible in the elaborated hierarchy.
    if ((HOLD_MAX < 1) || (HOLD_MAX > 65535)) begin : g_hold_max_out_of_range
    end

    state_t           state_q,   state_d;
    logic [ID_W-1:0]  ptr_q,     ptr_d;
    logic [N_REQ-1:0] gnt_q,     gnt_d;
    logic [ID_W-1:0]  gnt_id_q,  gnt_id_d;
    logic             timeout_q, timeout_d;

    logic             w_any;
    logic [ID_W-1:0]  w_win_id;
    logic [N_REQ-1:0] w_win_onehot;
    logic [ID_W-1:0]  w_pick_ptr;
    logic             w_force;
    logic             w_release;

    // In GRANT the only pick that matters is the one taken on release, which
    // must already use the advanced pointer owner+1; in IDLE the stored
    // pointer applies.
    assign w_pick_ptr = (state_q == ST_GRANT) ? (gnt_id_q + ID_W'(1)) : ptr_q;

    rr_pick8 u_pick (
        .req        (req),
        .ptr        (w_pick_ptr),
        .any        (w_any),
        .win_id     (w_win_id),
        .win_onehot (w_win_onehot)
    );

`ifdef ARB_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;

    // A done on the same edge takes precedence, so no timeout is flagged.
    assign w_force = (state_q == ST_GRANT) && !done && (hold_q == c_HOLD_LAST);

    // Counts completed GRANT cycles of the current owner; any release (which
    // either idles or starts a fresh grant) restarts it from zero.
    always_comb begin
        hold_d = '0;
        if ((state_q == ST_GRANT) && !w_release) begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign w_force = 1'b0;
`endif

    assign w_release = done || w_force;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_any) begin
                    state_d  = ST_GRANT;
                    gnt_d    = w_win_onehot;
                    gnt_id_d = w_win_id;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    ptr_d     = gnt_id_q + ID_W'(1);
                    timeout_d = w_force;
                    if (w_any) begin
                        gnt_d    = w_win_onehot;
                        gnt_id_d = w_win_id;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= c_PTR_RST;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = gnt_id_q;
    assign any_req   = w_any;
    assign timeout   = timeout_q;

endmodule : rr_arbiter8
`default_nettype wire

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one downstream resource among 8 requesters.
- An 8-way OR reduction of the request vector detects pending work.
- A rotating priority pointer picks the winner; the grant is held until the owner pulses done.
- Sits between the 8 request sources and the shared resource. It is the scheduler that sequences the OR-reduced request datapath.

Parameters:
- PTR_RST, 0, index (0-7) holding highest priority after reset.
- HOLD_MAX, 255, maximum grant length in cycles; used only when ARB_TIMEOUT_EN is defined; legal range 1-65535.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- req  input  8  request vector; bit k = requester k wants the resource.
- done  input  1  current owner releases the resource; sampled only in GRANT.
- gnt  output  8  registered one-hot grant; all zero when idle.
- gnt_valid  output  1  high while any grant is asserted (equals OR of gnt).
- gnt_id  output  3  binary index of the granted requester; holds its last value when idle.
- any_req  output  1  combinational OR of all 8 req bits.
- timeout  output  1  one-cycle pulse on forced release (see Optional Feature).

Behaviour:
- Reset, when rst_n is low at a clock edge:
  - gnt=0, gnt_valid=0, gnt_id=0, timeout=0.
  - ptr=PTR_RST, state=IDLE, hold counter=0.
- States:
  - IDLE: no grant.
  - GRANT: exactly one gnt bit high.
- Pick function:
  - Scan indices ptr, ptr+1, ..., ptr+7 (mod 8).
  - The first k with req[k]=1 wins.
- IDLE -> GRANT:
  - Condition: any_req=1 at the edge.
  - Actions: gnt <= onehot(winner), gnt_id <= winner.
  - Latency: 1 cycle from req rising to gnt.
- GRANT hold: done=0 keeps gnt, gnt_id and state unchanged. req changes are ignored, including the owner dropping its req.
- GRANT with done=1 at the edge:
  - ptr <= gnt_id+1 (mod 8, wraps 7->0).
  - The pick uses the new ptr value, i.e. starting at gnt_id+1.
  - If any_req=1: go straight to the next grant in the same edge (back-to-back, no idle cycle). The old owner may win again only if it is the sole requester.
  - If any_req=0: gnt <= 0, go to IDLE.
- done in IDLE: ignored.
- done together with rst_n=0: reset wins.
- Reset mid-grant: grant dropped on the next edge, ptr returns to PTR_RST.
- Fairness: with all 8 requesting continuously and done every cycle, gnt_id cycles 0,1,...,7,0 (PTR_RST=0). No requester waits more than 7 grants.
- gnt is always one-hot or zero; gnt_valid equals OR of gnt.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit hold counter clears on each new grant and increments every GRANT cycle without done.
  - Release is forced at the edge where the counter equals HOLD_MAX-1, i.e. the grant lasts HOLD_MAX cycles.
  - The forced release behaves exactly like done (ptr advance, back-to-back pick).
  - timeout is high for that one following cycle.
  - done arriving on the same edge counts as a normal release, timeout=0.
- Undefined: no counter; timeout tied to 0; the grant is held indefinitely until done.

Decomposition:
- Shared package/header arb_pkg:
  - N_REQ=8, ID_W=3.
  - State encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
  - HOLD_W=16.
- One combinational sub-module rr_pick8:
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: any (8-way OR), win_id[2:0], win_onehot[7:0].
  - Implementation: rotate by ptr, priority-encode, un-rotate.
- rr_arbiter8 holds only the FSM, ptr, output registers and the optional counter.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req=8'hFF -> gnt=0, gnt_valid=0, gnt_id=0, timeout=0. First grant after release of reset is gnt=8'h01.
- Single requester: req=8'h10 at cycle t -> gnt=8'h10, gnt_id=4 at t+1. gnt holds with done=0 for 5 cycles. done=1 with req dropped -> gnt=0 next cycle.
- Rotation: req=8'hFF held, done=1 every cycle -> gnt_id sequence 0,1,2,3,4,5,6,7,0. No idle cycle between grants.
- Wrap and skip: owner 6, req=8'h0B (bits 0,1,3), done=1 -> next gnt=8'h01. Next done -> 8'h02. Next done -> 8'h08.
- Mid-grant reset: gnt=8'h20 held, rst_n=0 one cycle with req=8'h21 -> gnt=0 that edge. After reset, gnt=8'h01 (PTR_RST=0).
- ARB_TIMEOUT_EN, HOLD_MAX=4: req=8'h03 with done=0 -> gnt=8'h01 for exactly 4 cycles, then gnt=8'h02 with timeout=1 for 1 cycle. Without the macro -> gnt=8'h01 stays, timeout=0.
